bitwise_op_arbiter: RTL and testbench
=====================================

Name: bitwise_op_arbiter

Overview:
Shares one registered 7-bit bitwise compute stage (AND/OR/XOR/NAND) between two requesters. Each requester uses a valid/ready handshake. Grants are round-robin, one transaction is in flight at a time, and results return on a shared response channel tagged with the requester id. The block sits between command sources (e.g. switch/button front-ends) and display/result logic.

Parameters:
WIDTH, 7, operand and result width in bits
CNT_W, 8, width of per-requester completion counters

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 command valid
req0_ready  output  1  requester 0 command accepted this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_op  input  2  requester 0 opcode
req1_valid  input  1  requester 1 command valid
req1_ready  output  1  requester 1 command accepted this cycle
req1_a  input  WIDTH  requester 1 operand a
req1_b  input  WIDTH  requester 1 operand b
req1_op  input  2  requester 1 opcode
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  1  requester that issued the result
rsp_q  output  WIDTH  result
busy  output  1  high whenever state != IDLE
done_cnt0  output  CNT_W  completed transactions for requester 0, saturating
done_cnt1  output  CNT_W  completed transactions for requester 1, saturating

Behaviour:
- Reset is asynchronous (rst_n low). It forces state=IDLE, prio=0, rsp_valid=0, rsp_id=0, rsp_q=0, done_cnt0/1=0, busy=0, and clears the latched operands.
- Opcodes: 00 = a&b, 01 = a|b, 10 = a^b, 11 = ~(a&b) (all WIDTH bits).
- State machine has three states: IDLE, EXEC, RESP.
- IDLE:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester equal to prio is granted.
  - reqN_ready is combinational and high only in IDLE for the granted requester.
  - Handshake completes when valid && ready. On that edge: latch a, b, op and id, then go to EXEC.
  - If neither is valid, stay in IDLE.
- EXEC (one cycle): compute the result from the latched operands into rsp_q, set rsp_id, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_q and rsp_id stable until rsp_ready is high.
  - On the edge where rsp_valid && rsp_ready:
    - rsp_valid goes to 0.
    - done_cnt[rsp_id] increments, saturating at 2^CNT_W-1.
    - prio becomes the opposite of rsp_id.
    - State goes to IDLE.
- Latency: handshake at edge E0 gives rsp_valid high in the cycle after E0+1. Peak throughput is one transaction per 3 cycles when rsp_ready is held high.
- Both reqN_ready are 0 in EXEC and RESP; no new request is accepted while a transaction is in flight.
- Requesters must hold valid and operands stable until ready. The block samples operands only at the handshake edge.
- If prio points at an idle requester, the other requester wins. prio changes only on response completion.
- Reset mid-transaction drops the transaction with no response. Counters and prio return to 0.
- rsp_ready high while rsp_valid is low has no effect.

Decomposition:
- Package bitwise_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11
  - state encoding IDLE/EXEC/RESP
  - default WIDTH
- Sub-module rr_arb2: combinational 2-way round-robin grant logic (valid0, valid1, prio in; grant_id, grant_any out).
- Compute, FSM and counters stay in the top module.

Test Plan:
- Reset: rst_n low while req0_valid=1 -> all outputs 0, req0_ready=0. After release, req0_ready=1 in IDLE.
- Single requester, rsp_ready=1:
  - req0 sends a=7'h55, b=7'h33 with op=00, 01, 10 and 11 in turn.
  - Required rsp_q values are 7'h11, 7'h77, 7'h66 and 7'h6E, each with rsp_id=0.
  - Each rsp_valid is high 2 cycles after the handshake edge.
  - done_cnt0=4 at the end.
- Contention: both valid continuously with distinct operands -> grants alternate 0,1,0,1, starting at 0 after reset. rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_q and rsp_id stay stable, both readys stay 0, busy=1. rsp_ready=1 -> completes in one cycle, then IDLE.
- Reset mid-op: assert rst_n low during EXEC -> no response appears, state is IDLE, done counts are 0. The next request completes normally.
- Saturation (CNT_W=2 override): 5 req1 transactions -> done_cnt1 reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/bitwise_op_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitwise_pkg: opcodes, FSM encoding and default sizes shared by the  |
// | bitwise_op_arbiter slice.                        Revision: 1.0      |
// +--------------------------------------------------------------------+
package bitwise_pkg;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_CNT_W = 8;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bitwise_op_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitwise_op_arbiter_if: two request channels, shared response       |
// | channel and status.                              Revision: 1.0      |
// +--------------------------------------------------------------------+
interface bitwise_op_arbiter_if
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_q;

  logic             busy;
  logic [CNT_W-1:0] done_cnt0;
  logic [CNT_W-1:0] done_cnt1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_q,
    input  busy, done_cnt0, done_cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_q,
    output busy, done_cnt0, done_cnt1
  );

endinterface
`default_nettype wire

// File: rtl/bitwise_op_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb2: combinational two-way round-robin grant.                  |
// |                                                  Revision: 1.0      |
// +--------------------------------------------------------------------+
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic prio_i,
  output logic grant_id_o,
  output logic grant_any_o
);

  // prio only matters on contention; a lone requester always wins.
  assign grant_any_o = valid0_i | valid1_i;
  assign grant_id_o  = (valid0_i & valid1_i) ? prio_i : valid1_i;

endmodule
`default_nettype wire

// File: rtl/bitwise_op_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitwise_op_arbiter: one registered AND/OR/XOR/NAND stage shared by  |
// | two requesters, one transaction in flight.       Revision: 1.0      |
// +--------------------------------------------------------------------+
module bitwise_op_arbiter
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitwise_op_arbiter_if.slave  bus
);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             grant_id;
  logic             grant_any;
  logic [WIDTH-1:0] alu;

  rr_arb2 u_arb (
    .valid0_i    (bus.req0_valid),
    .valid1_i    (bus.req1_valid),
    .prio_i      (prio_q),
    .grant_id_o  (grant_id),
    .grant_any_o (grant_any)
  );

  // Gated by rst_n so a held valid is never acknowledged while in reset.
  assign bus.req0_ready = rst_n && (state_q == IDLE) && grant_any && !grant_id;
  assign bus.req1_ready = rst_n && (state_q == IDLE) && grant_any &&  grant_id;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = res_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done_cnt0 = cnt0_q;
  assign bus.done_cnt1 = cnt1_q;

  always_comb begin
    alu = '0;
    case (op_q)
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_XOR:  alu = a_q ^ b_q;
      default: alu = ~(a_q & b_q);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    res_d       = res_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          a_d     = grant_id ? bus.req1_a  : bus.req0_a;
          b_d     = grant_id ? bus.req1_b  : bus.req0_b;
          op_d    = grant_id ? bus.req1_op : bus.req0_op;
          id_d    = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d       = alu;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          prio_d      = ~rsp_id_q;
          state_d     = IDLE;
          if (rsp_id_q) begin
            if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + 1'b1;
          end else begin
            if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      res_q       <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      res_q       <= res_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitwise_op_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bitwise_op_arbiter: directed vectors, corner sequences and a     |
// | randomized run against a transaction-level model. Revision: 1.0     |
// +--------------------------------------------------------------------+
module tb_bitwise_op_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitwise_op_arbiter_if #(.WIDTH(7), .CNT_W(8)) bus ();
  bitwise_op_arbiter_if #(.WIDTH(7), .CNT_W(2)) bus2 ();

  bitwise_op_arbiter #(.WIDTH(7), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  bitwise_op_arbiter #(.WIDTH(7), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_op(input logic [1:0] op, input logic [6:0] a, input logic [6:0] b);
    int r;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = 127 - (a & b);
    endcase
    return r[6:0];
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.rsp_ready  = 0;
    bus2.req0_valid = 0; bus2.req0_a = 0; bus2.req0_b = 0; bus2.req0_op = 0;
    bus2.req1_valid = 0; bus2.req1_a = 0; bus2.req1_b = 0; bus2.req1_op = 0;
    bus2.rsp_ready  = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1;
  endtask

  // Full transaction on the 8-bit-counter instance with rsp_ready held high.
  task automatic do_txn(input logic id, input logic [1:0] op, input logic [6:0] a,
                        input logic [6:0] b, input logic [6:0] exp, input string tag);
    if (id) begin
      bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
    bus.rsp_ready = 1;
    #1;
    chk({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1);
    @(posedge clk); #2;
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    chk({tag, "_exec_valid"}, bus.rsp_valid, 0);
    chk({tag, "_exec_busy"}, bus.busy, 1);
    @(posedge clk); #2;
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    chk({tag, "_rsp_q"}, bus.rsp_q, exp);
    chk({tag, "_rsp_id"}, bus.rsp_id, id);
    @(posedge clk); #2;
    chk({tag, "_done_valid"}, bus.rsp_valid, 0);
    chk({tag, "_done_busy"}, bus.busy, 0);
  endtask

  // Transaction-level model state for the randomized run.
  logic       m_have, m_id, m_prio, acc0, acc1, e_r0, e_r1, e_rv, rr_now;
  logic [6:0] m_res;
  int         m_t0, t, m_cnt0, m_cnt1;

  initial begin
    tbl[0] = '{1'b0, 2'b00, 7'h55, 7'h33, 7'h11};
    tbl[1] = '{1'b0, 2'b01, 7'h55, 7'h33, 7'h77};
    tbl[2] = '{1'b0, 2'b10, 7'h55, 7'h33, 7'h66};
    tbl[3] = '{1'b0, 2'b11, 7'h55, 7'h33, 7'h6E};
    tbl[4] = '{1'b1, 2'b10, 7'h7F, 7'h0F, 7'h70};
    tbl[5] = '{1'b1, 2'b11, 7'h00, 7'h2A, 7'h7F};

    // Reset with a request pending.
    idle_inputs();
    bus.req0_valid = 1; bus.req0_a = 7'h55; bus.req0_b = 7'h33;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_q", bus.rsp_q, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt0", bus.done_cnt0, 0);
    chk("rst_cnt1", bus.done_cnt1, 0);
    rst_n = 1;
    #1;
    chk("post_rst_req0_ready", bus.req0_ready, 1);
    @(posedge clk); #2;
    do_reset();

    for (int i = 0; i < 6; i++)
      do_txn(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
    chk("vec_cnt0", bus.done_cnt0, 4);
    chk("vec_cnt1", bus.done_cnt1, 2);

    // Contention: both valid throughout, grants alternate from 0.
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 7'h55; bus.req0_b = 7'h33; bus.req0_op = 2'b01;
    bus.req1_valid = 1; bus.req1_a = 7'h0F; bus.req1_b = 7'h3C; bus.req1_op = 2'b00;
    bus.rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont%0d_ready0", k), bus.req0_ready, (k % 2) == 0);
      chk($sformatf("cont%0d_ready1", k), bus.req1_ready, (k % 2) == 1);
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk($sformatf("cont%0d_rsp_id", k), bus.rsp_id, k % 2);
      chk($sformatf("cont%0d_rsp_q", k), bus.rsp_q, (k % 2) ? 7'h0C : 7'h77);
      @(posedge clk); #1;
    end
    idle_inputs();
    #1;
    chk("cont_cnt0", bus.done_cnt0, 2);
    chk("cont_cnt1", bus.done_cnt1, 2);

    // Backpressure: response held for 5 cycles with both requesters waiting.
    bus.req1_valid = 1; bus.req1_a = 7'h2A; bus.req1_b = 7'h15; bus.req1_op = 2'b10;
    bus.rsp_ready = 0;
    @(posedge clk); #2;
    bus.req1_valid = 0;
    @(posedge clk); #2;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_q", bus.rsp_q, 7'h3F);
      chk("bp_rsp_id", bus.rsp_id, 1);
      chk("bp_ready0", bus.req0_ready, 0);
      chk("bp_ready1", bus.req1_ready, 0);
      chk("bp_busy", bus.busy, 1);
      @(posedge clk); #1;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp_ready = 1;
    @(posedge clk); #2;
    chk("bp_done_valid", bus.rsp_valid, 0);
    chk("bp_done_busy", bus.busy, 0);
    chk("bp_cnt1", bus.done_cnt1, 3);

    // Reset during EXEC drops the transaction.
    bus.req0_valid = 1; bus.req0_a = 7'h55; bus.req0_b = 7'h33; bus.req0_op = 2'b00;
    @(posedge clk); #2;
    bus.req0_valid = 0;
    rst_n = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rmid_rsp_valid", bus.rsp_valid, 0);
      chk("rmid_busy", bus.busy, 0);
      @(posedge clk); #1;
    end
    rst_n = 1;
    @(posedge clk); #2;
    chk("rmid_after_valid", bus.rsp_valid, 0);
    chk("rmid_cnt0", bus.done_cnt0, 0);
    chk("rmid_cnt1", bus.done_cnt1, 0);
    do_txn(1'b0, 2'b00, 7'h55, 7'h33, 7'h11, "rmid_next");
    chk("rmid_next_cnt0", bus.done_cnt0, 1);

    // Saturating 2-bit counter instance.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus2.req1_valid = 1; bus2.req1_a = 7'h12; bus2.req1_b = 7'h34; bus2.req1_op = 2'b01;
      bus2.rsp_ready = 1;
      @(posedge clk); #2;
      bus2.req1_valid = 0;
      @(posedge clk); #2;
      chk("sat_rsp_q", bus2.rsp_q, 7'h36);
      @(posedge clk); #2;
      chk($sformatf("sat_cnt1_%0d", k), bus2.done_cnt1, (k + 1 > 3) ? 3 : k + 1);
    end

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_have = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0; t = 0; acc0 = 0; acc1 = 0;
    m_id = 0; m_res = 0; m_t0 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 99) < 55);
        bus.req0_a = 7'($urandom); bus.req0_b = 7'($urandom); bus.req0_op = 2'($urandom);
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 99) < 55);
        bus.req1_a = 7'($urandom); bus.req1_b = 7'($urandom); bus.req1_op = 2'($urandom);
      end
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (!m_have) begin
        e_r0 = bus.req0_valid && (!bus.req1_valid || !m_prio);
        e_r1 = bus.req1_valid && (!bus.req0_valid ||  m_prio);
        e_rv = 0;
      end else begin
        e_r0 = 0; e_r1 = 0;
        e_rv = (t - m_t0) >= 2;
      end
      chk("rnd_ready0", bus.req0_ready, e_r0);
      chk("rnd_ready1", bus.req1_ready, e_r1);
      chk("rnd_busy", bus.busy, m_have);
      chk("rnd_rsp_valid", bus.rsp_valid, e_rv);
      if (e_rv) begin
        chk("rnd_rsp_id", bus.rsp_id, m_id);
        chk("rnd_rsp_q", bus.rsp_q, m_res);
      end
      chk("rnd_cnt0", bus.done_cnt0, m_cnt0);
      chk("rnd_cnt1", bus.done_cnt1, m_cnt1);
      rr_now = bus.rsp_ready;
      @(posedge clk);
      acc0 = e_r0; acc1 = e_r1;
      if (m_have && e_rv && rr_now) begin
        if (m_id) m_cnt1 = (m_cnt1 == 255) ? 255 : m_cnt1 + 1;
        else      m_cnt0 = (m_cnt0 == 255) ? 255 : m_cnt0 + 1;
        m_prio = !m_id;
        m_have = 0;
      end else if (!m_have && (e_r0 || e_r1)) begin
        m_have = 1;
        m_t0   = t;
        m_id   = e_r1;
        m_res  = e_r1 ? ref_op(bus.req1_op, bus.req1_a, bus.req1_b)
                      : ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
      end
      t++;
      #2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
